// File: rtl/fusion_array_ctrl.sv
// Tile sequencer for an N x N systolic array: loads weights and inputs, feeds
// the array with a diagonal skew, writes the partial sums back, then pulses done.
module fusion_array_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int INPUT_W    = 8,
    parameter int WEIGHT_W   = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10
) (
    input  logic                                clk,
    input  logic                                nRST,
    input  logic                                i_start,
    input  logic                                i_clear,
    output logic                                o_busy,
    output logic                                o_done,
    input  logic [2:0]                          i_op0_precision,
    input  logic [2:0]                          i_op1_precision,
    input  logic [ADDR_W-1:0]                   i_input_base_addr,
    input  logic [ADDR_W-1:0]                   i_weight_base_addr,
    input  logic [ADDR_W-1:0]                   i_output_base_addr,
    output logic [ADDR_W-1:0]                   o_mem_addr,
    output logic                                o_mem_rd_en,
    output logic                                o_mem_wr_en,
    input  logic [ARRAY_SIZE*INPUT_W-1:0]       i_mem_rdata,
    output logic [DATA_W-1:0]                   o_mem_wdata,
    output logic [2:0]                          o_input_precision,
    output logic [2:0]                          o_weight_precision,
    output logic                                o_compute_en,
    output logic                                o_w_load_en,
    output logic [$clog2(ARRAY_SIZE)-1:0]       o_w_row_sel,
    output logic [ARRAY_SIZE*WEIGHT_W-1:0]      o_w_row_data,
    output logic [ARRAY_SIZE*INPUT_W-1:0]       o_input_forward,
    input  logic [ARRAY_SIZE*DATA_W-1:0]        i_psum_in
);
    localparam int N     = ARRAY_SIZE;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(3*N-1);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N-1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(3*N-3);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LD_WEIGHT, S_LD_INPUT, S_COMPUTE, S_ST_OUTPUT, S_DONE
    } state_t;

    state_t                                 r_state;
    logic [CNT_W-1:0]                       r_cnt;
    logic [2:0]                             r_in_prec;
    logic [2:0]                             r_w_prec;
    logic [ADDR_W-1:0]                      r_wbase;
    logic [ADDR_W-1:0]                      r_ibase;
    logic [ADDR_W-1:0]                      r_obase;
    logic [N-1:0][N-1:0][INPUT_W-1:0]       r_ibuf;

    logic [IDX_W-1:0]                       w_k;
    logic [ADDR_W-1:0]                      w_cnt_a;
    logic [N-1:0][DATA_W-1:0]               w_psum;

    assign w_k     = r_cnt[IDX_W-1:0];
    assign w_cnt_a = ADDR_W'(r_cnt);
    assign w_psum  = i_psum_in;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_in_prec <= '0;
            r_w_prec  <= '0;
            r_wbase   <= '0;
            r_ibase   <= '0;
            r_obase   <= '0;
            r_ibuf    <= '0;
        end else if (i_clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (i_start) r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_in_prec <= i_op0_precision;
                    r_w_prec  <= i_op1_precision;
                    r_wbase   <= i_weight_base_addr;
                    r_ibase   <= i_input_base_addr;
                    r_obase   <= i_output_base_addr;
                    r_cnt     <= '0;
                    r_state   <= S_LD_WEIGHT;
                end
                S_LD_WEIGHT: begin
                    if (r_cnt == LAST_K) begin
                        r_cnt   <= '0;
                        r_state <= S_LD_INPUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LD_INPUT: begin
                    for (int j = 0; j < N; j++)
                        r_ibuf[j][w_k] <= i_mem_rdata[j*INPUT_W +: INPUT_W];
                    if (r_cnt == LAST_K) begin
                        r_cnt   <= '0;
                        r_state <= S_COMPUTE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (r_cnt == LAST_C) begin
                        r_cnt   <= '0;
                        r_state <= S_ST_OUTPUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ST_OUTPUT: begin
                    if (r_cnt == LAST_K) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the registered state, so reset zeroes them at once.
    always_comb begin
        o_mem_addr   = '0;
        o_mem_rd_en  = 1'b0;
        o_mem_wr_en  = 1'b0;
        o_mem_wdata  = '0;
        o_compute_en = 1'b0;
        o_w_load_en  = 1'b0;
        o_w_row_sel  = '0;
        o_w_row_data = '0;
        case (r_state)
            S_LD_WEIGHT: begin
                o_mem_rd_en  = 1'b1;
                o_mem_addr   = r_wbase + w_cnt_a;
                o_w_load_en  = 1'b1;
                o_w_row_sel  = w_k;
                o_w_row_data = (N*WEIGHT_W)'(i_mem_rdata);
            end
            S_LD_INPUT: begin
                o_mem_rd_en = 1'b1;
                o_mem_addr  = r_ibase + w_cnt_a;
            end
            S_COMPUTE: o_compute_en = 1'b1;
            S_ST_OUTPUT: begin
                o_mem_wr_en = 1'b1;
                o_mem_addr  = r_obase + w_cnt_a;
                o_mem_wdata = w_psum[w_k];
            end
            default: ;
        endcase
    end

    assign o_busy             = (r_state != S_IDLE);
    assign o_done             = (r_state == S_DONE);
    assign o_input_precision  = r_in_prec;
    assign o_weight_precision = r_w_prec;

    // Lane j lags lane 0 by j cycles: it shows element c-j while that index is in range.
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [CNT_W:0] w_diff;
        logic           w_live;
        assign w_diff = {1'b0, r_cnt} - (CNT_W+1)'(j);
        assign w_live = (r_state == S_COMPUTE) && (r_cnt >= CNT_W'(j)) &&
                        (w_diff < (CNT_W+1)'(N));
        assign o_input_forward[j*INPUT_W +: INPUT_W] =
            w_live ? r_ibuf[j][w_diff[IDX_W-1:0]] : '0;
    end
endmodule

// File: tb/tb_fusion_array_ctrl.sv
// Bench for fusion_array_ctrl: per-cycle trace model of a tile, vector table,
// abort/reset corner sequences and randomized tiles.
module tb_fusion_array_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         nRST;
    logic         i_start, i_clear;
    logic [2:0]   i_op0, i_op1;
    logic [9:0]   i_ib, i_wb, i_ob;
    logic [31:0]  i_mem_rdata;
    logic [127:0] i_psum_in;
    logic         o_busy, o_done, o_mem_rd_en, o_mem_wr_en, o_compute_en, o_w_load_en;
    logic [9:0]   o_mem_addr;
    logic [31:0]  o_mem_wdata, o_w_row_data, o_input_forward;
    logic [2:0]   o_ip, o_wp;
    logic [1:0]   o_w_row_sel;

    logic [31:0]  mem [0:1023];
    assign i_mem_rdata = mem[o_mem_addr];

    fusion_array_ctrl dut (
        .clk(clk), .nRST(nRST), .i_start(i_start), .i_clear(i_clear),
        .o_busy(o_busy), .o_done(o_done),
        .i_op0_precision(i_op0), .i_op1_precision(i_op1),
        .i_input_base_addr(i_ib), .i_weight_base_addr(i_wb), .i_output_base_addr(i_ob),
        .o_mem_addr(o_mem_addr), .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en),
        .i_mem_rdata(i_mem_rdata), .o_mem_wdata(o_mem_wdata),
        .o_input_precision(o_ip), .o_weight_precision(o_wp),
        .o_compute_en(o_compute_en), .o_w_load_en(o_w_load_en),
        .o_w_row_sel(o_w_row_sel), .o_w_row_data(o_w_row_data),
        .o_input_forward(o_input_forward), .i_psum_in(i_psum_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [9:0]   m_wb, m_ib, m_ob;
    logic [127:0] m_psum;
    logic [2:0]   m_ip_old = 0, m_ip_new = 0, m_wp_old = 0, m_wp_new = 0;
    logic [31:0]  cap_fwd [0:3*N-3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk(nm, {o_busy, o_done, o_mem_rd_en, o_mem_wr_en, o_compute_en, o_w_load_en,
                 o_mem_addr, o_mem_wdata, o_w_row_data, o_input_forward, o_ip, o_wp,
                 o_w_row_sel}, 128'd0);
    endtask

    // Expected outputs for cycle i of a tile, counted from the SETUP cycle (i=0).
    task automatic check_cycle(input int i);
        logic [5:0]  ctl;
        logic [9:0]  a;
        logic [1:0]  rs;
        logic [31:0] wr, fw, wd, row;
        int k, c;
        ctl = '0; a = '0; rs = '0; wr = '0; fw = '0; wd = '0;
        if (i < 6*N) ctl[5] = 1'b1;
        if (i >= 1 && i <= N) begin
            k = i - 1; ctl[3] = 1'b1; ctl[1] = 1'b1;
            a = 10'((m_wb + k) % 1024); rs = 2'(k); wr = mem[a];
        end else if (i >= N+1 && i <= 2*N) begin
            k = i - N - 1; ctl[3] = 1'b1;
            a = 10'((m_ib + k) % 1024);
        end else if (i >= 2*N+1 && i <= 5*N-2) begin
            c = i - 2*N - 1; ctl[0] = 1'b1;
            for (int j = 0; j < N; j++)
                if (c - j >= 0 && c - j < N) begin
                    row = mem[10'((m_ib + c - j) % 1024)];
                    fw[j*8 +: 8] = row[j*8 +: 8];
                end
        end else if (i >= 5*N-1 && i <= 6*N-2) begin
            k = i - 5*N + 1; ctl[2] = 1'b1;
            a = 10'((m_ob + k) % 1024); wd = m_psum[k*32 +: 32];
        end else if (i == 6*N-1) begin
            ctl[4] = 1'b1;
        end
        chk($sformatf("ctrl@%0d", i), {o_busy, o_done, o_mem_rd_en, o_mem_wr_en,
                                        o_w_load_en, o_compute_en}, ctl);
        chk($sformatf("addr@%0d", i), o_mem_addr, a);
        chk($sformatf("rowsel@%0d", i), o_w_row_sel, rs);
        chk($sformatf("wrow@%0d", i), o_w_row_data, wr);
        chk($sformatf("fwd@%0d", i), o_input_forward, fw);
        chk($sformatf("wdata@%0d", i), o_mem_wdata, wd);
        chk($sformatf("prec@%0d", i), {o_ip, o_wp},
            (i == 0) ? {m_ip_old, m_wp_old} : {m_ip_new, m_wp_new});
    endtask

    // Caller sits at a negedge with the DUT idle; returns at the negedge after the tile.
    task automatic run_tile(input logic [9:0] wb, ib, ob, input logic [2:0] op0, op1,
                            input bit hold, input int pulse_at, clear_at, rst_at,
                            output int done_i, output logic [9:0] in_a3, out_a3);
        m_wb = wb; m_ib = ib; m_ob = ob; m_ip_new = op0; m_wp_new = op1;
        m_psum = {$urandom, $urandom, $urandom, $urandom};
        i_wb = wb; i_ib = ib; i_ob = ob; i_op0 = op0; i_op1 = op1; i_psum_in = m_psum;
        i_start = 1'b1; done_i = -1; in_a3 = '0; out_a3 = '0;
        for (int i = 0; i <= 6*N; i++) begin
            @(negedge clk);
            if (i == 0 && !hold) i_start = 1'b0;
            if (o_done) done_i = i;
            if (i == 2*N) in_a3 = o_mem_addr;
            if (i == 6*N-2) out_a3 = o_mem_addr;
            if (i >= 2*N+1 && i <= 5*N-2) cap_fwd[i-2*N-1] = o_input_forward;
            check_cycle(i);
            if (i == pulse_at) begin
                i_start = 1'b1; i_op0 = ~op0; i_op1 = ~op1;
            end
            if (i == pulse_at + 1) i_start = 1'b0;
            if (i == clear_at) begin
                i_clear = 1'b1;
                @(negedge clk);
                i_clear = 1'b0;
                if (o_done) done_i = 99;
                check_cycle(6*N);
                m_ip_old = m_ip_new; m_wp_old = m_wp_new;
                return;
            end
            if (i == rst_at) begin
                #2 nRST = 1'b0;
                #1 check_all_zero("async_reset");
                @(negedge clk);
                nRST = 1'b1;
                @(negedge clk);
                if (o_done) done_i = 99;
                check_all_zero("after_reset");
                m_ip_old = 0; m_wp_old = 0; m_ip_new = 0; m_wp_new = 0;
                return;
            end
        end
        m_ip_old = m_ip_new; m_wp_old = m_wp_new;
    endtask

    typedef struct {
        logic [9:0] wb, ib, ob;
        logic [2:0] op0, op1;
        int         exp_done;
        logic [9:0] exp_in3, exp_out3;
    } vec_t;
    vec_t        tbl [4];
    int          d;
    logic [9:0]  a3, o3;
    logic [31:0] row;

    initial begin
        tbl[0] = '{10'h010, 10'h020, 10'h030, 3'd1, 3'd2, 23, 10'h023, 10'h033};
        tbl[1] = '{10'h100, 10'h3FE, 10'h200, 3'd7, 3'd0, 23, 10'h001, 10'h203};
        tbl[2] = '{10'h3FD, 10'h000, 10'h3FF, 3'd4, 3'd5, 23, 10'h003, 10'h002};
        tbl[3] = '{10'h3FF, 10'h3FC, 10'h3FE, 3'd3, 3'd6, 23, 10'h3FF, 10'h001};
        for (int r = 0; r < 1024; r++)
            mem[r] = {8'(r*4+3), 8'(r*4+2), 8'(r*4+1), 8'(r*4)};

        nRST = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_op0 = 3'd5; i_op1 = 3'd6;
        i_wb = '0; i_ib = '0; i_ob = '0; i_psum_in = '1;
        #1 check_all_zero("reset_state");
        @(negedge clk); @(negedge clk);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cycle(6*N);
        end

        for (int t = 0; t < 4; t++) begin
            run_tile(tbl[t].wb, tbl[t].ib, tbl[t].ob, tbl[t].op0, tbl[t].op1,
                     1'b0, -10, -1, -1, d, a3, o3);
            chk($sformatf("tbl%0d_done", t), d, tbl[t].exp_done);
            chk($sformatf("tbl%0d_in3", t), a3, tbl[t].exp_in3);
            chk($sformatf("tbl%0d_out3", t), o3, tbl[t].exp_out3);
        end

        // Skew: lane j of input row k holds 4j+k+1.
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) row[j*8 +: 8] = 8'(4*j + k + 1);
            mem[10'h020 + k] = row;
        end
        run_tile(10'h010, 10'h020, 10'h030, 3'd2, 3'd3, 1'b0, -10, -1, -1, d, a3, o3);
        for (int c = 0; c <= 3*N-3; c++) begin
            chk($sformatf("skew_l0_c%0d", c), cap_fwd[c][7:0], (c < 4) ? 8'(c + 1) : 8'd0);
            chk($sformatf("skew_l3_c%0d", c), cap_fwd[c][31:24],
                (c >= 3 && c <= 6) ? 8'(c + 10) : 8'd0);
        end

        run_tile(10'h040, 10'h050, 10'h060, 3'd6, 3'd1, 1'b0, -10, 2*N+2, -1, d, a3, o3);
        chk("clear_no_done", d, -1);
        run_tile(10'h040, 10'h050, 10'h060, 3'd4, 3'd4, 1'b0, -10, -1, -1, d, a3, o3);
        chk("after_clear_done", d, 23);

        run_tile(10'h070, 10'h080, 10'h090, 3'd1, 3'd7, 1'b1, -10, -1, -1, d, a3, o3);
        chk("hold1_done", d, 23);
        run_tile(10'h070, 10'h080, 10'h090, 3'd1, 3'd7, 1'b1, -10, -1, -1, d, a3, o3);
        chk("hold2_done", d, 23);
        i_start = 1'b0;
        @(negedge clk);
        check_cycle(6*N);

        run_tile(10'h0A0, 10'h0B0, 10'h0C0, 3'd3, 3'd2, 1'b0, N+2, -1, -1, d, a3, o3);
        chk("pulse_done", d, 23);
        @(negedge clk);
        check_cycle(6*N);

        run_tile(10'h0D0, 10'h0E0, 10'h0F0, 3'd5, 3'd5, 1'b0, -10, -1, 5*N, d, a3, o3);
        chk("rst_no_done", d, -1);

        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < 1024; r++) mem[r] = $urandom;
            run_tile(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                     10'($urandom_range(0, 1023)), 3'($urandom), 3'($urandom),
                     1'b0, -10, -1, -1, d, a3, o3);
            chk($sformatf("rand%0d_done", t), d, 23);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
